// File: rtl/key_event_decoder.sv
// -----------------------------------------------------------------------------
// key_event_decoder
//
// Purpose:
//   Turns the four debounced, active-low key levels (Up/Down/Left/Right) into
//   single-cycle key events: press, auto-repeat while the key stays held, and
//   (optionally) release. Only one key is tracked at a time. Among keys that
//   are pressed together, Up > Down > Left > Right wins. Because only one key
//   is tracked, downstream menu/cursor logic never sees simultaneous events.
//
// Optional feature:
//   KEY_RELEASE_EVENT_EN  when defined, leaving HOLD/REPEAT because the tracked
//                         key was released emits one event with
//                         Event_Type = 2'b10. When undefined, release is silent.
//
// Parameters:
//   CLK_FREQ_HZ  clock frequency; one millisecond is CLK_FREQ_HZ/1000 cycles
//   HOLD_MS      hold time in ms before the first repeat event
//   REPEAT_MS    time in ms between subsequent repeat events
//
// Ports:
//   CLK          in   1  system clock, rising edge
//   RST_N        in   1  asynchronous reset, active-low
//   Key_In       in   4  debounced keys, 0 = pressed; [3]=Up [2]=Down [1]=Left [0]=Right
//   Event_Valid  out  1  one-cycle strobe qualifying Event_Code / Event_Type
//   Event_Code   out  2  key index of the event (3=Up, 2=Down, 1=Left, 0=Right)
//   Event_Type   out  2  00=press, 01=repeat, 10=release
//   Key_Held     out  1  high while a key is tracked (HOLD or REPEAT)
// -----------------------------------------------------------------------------
module key_event_decoder #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int HOLD_MS     = 500,
  parameter int REPEAT_MS   = 100
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] Key_In,
  output logic       Event_Valid,
  output logic [1:0] Event_Code,
  output logic [1:0] Event_Type,
  output logic       Key_Held
);

  // Timer geometry. The prescaler counts 0..TICKS-1; a width of 1 is kept
  // even when TICKS is 1 so the vector is never zero-width.
  localparam int TICKS   = (CLK_FREQ_HZ / 1000 > 1) ? CLK_FREQ_HZ / 1000 : 1;
  localparam int PRESC_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int MS_MAX  = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
  localparam int MS_W    = $clog2(MS_MAX + 1);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS - 1);
  localparam logic [MS_W-1:0]    MS_SAT     = MS_W'(MS_MAX);
  localparam logic [MS_W-1:0]    HOLD_T     = MS_W'(HOLD_MS);
  localparam logic [MS_W-1:0]    REPEAT_T   = MS_W'(REPEAT_MS);

  localparam logic [1:0] TYPE_PRESS   = 2'b00;
  localparam logic [1:0] TYPE_REPEAT  = 2'b01;
`ifdef KEY_RELEASE_EVENT_EN
  localparam logic [1:0] TYPE_RELEASE = 2'b10;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [3:0]         key_reg;
  logic [PRESC_W-1:0] presc_reg, presc_next, presc_inc;
  logic [MS_W-1:0]    ms_reg, ms_next, ms_inc;
  logic               valid_reg, valid_next;
  logic [1:0]         code_reg, code_next;
  logic [1:0]         type_reg, type_next;
  logic               held_reg, held_next;

  logic               tick;
  logic               any_pressed;
  logic [1:0]         top_code;
  logic               tracked_released;
  logic [MS_W-1:0]    deadline;

  // Highest pressed index wins: later loop iterations override earlier ones.
  always_comb begin
    top_code = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!key_reg[i]) begin
        top_code = 2'(i);
      end
    end
  end

  assign any_pressed      = ~&key_reg;
  // code_reg doubles as the tracked key index: it is only loaded on a press.
  assign tracked_released = key_reg[code_reg];
  assign deadline         = (state_reg == HOLD) ? HOLD_T : REPEAT_T;

  // Free-running ms timebase while a key is tracked. The ms counter
  // saturates so a stalled deadline can never wrap back to zero.
  assign tick      = (presc_reg == PRESC_LAST);
  assign presc_inc = tick ? '0 : presc_reg + 1'b1;
  assign ms_inc    = (tick && (ms_reg != MS_SAT)) ? ms_reg + 1'b1 : ms_reg;

  always_comb begin
    state_next = state_reg;
    valid_next = 1'b0;
    code_next  = code_reg;
    type_next  = type_reg;
    presc_next = presc_inc;
    ms_next    = ms_inc;

    case (state_reg)
      IDLE: begin
        presc_next = '0;
        ms_next    = '0;
        // The valid_reg guard keeps a press from directly following a
        // release event, so the strobe is never high two cycles in a row.
        if (any_pressed && !valid_reg) begin
          state_next = HOLD;
          valid_next = 1'b1;
          code_next  = top_code;
          type_next  = TYPE_PRESS;
        end
      end

      HOLD, REPEAT: begin
        // Release is tested first so it wins over a coincident repeat.
        if (tracked_released) begin
`ifdef KEY_RELEASE_EVENT_EN
          // If an event went out last cycle, stay one more cycle and emit
          // the release then; no repeat can fire in the meantime.
          if (!valid_reg) begin
            state_next = IDLE;
            valid_next = 1'b1;
            type_next  = TYPE_RELEASE;
            presc_next = '0;
            ms_next    = '0;
          end
`else
          state_next = IDLE;
          presc_next = '0;
          ms_next    = '0;
`endif
        end else if ((ms_inc >= deadline) && !valid_reg) begin
          // Compare against the incremented count so the repeat lands on
          // the exact cycle the ms count reaches the deadline.
          state_next = REPEAT;
          valid_next = 1'b1;
          type_next  = TYPE_REPEAT;
          presc_next = '0;
          ms_next    = '0;
        end
      end

      default: begin
        state_next = IDLE;
        presc_next = '0;
        ms_next    = '0;
      end
    endcase
  end

  assign held_next = (state_next != IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
      key_reg   <= 4'b1111;
      presc_reg <= '0;
      ms_reg    <= '0;
      valid_reg <= 1'b0;
      code_reg  <= 2'd0;
      type_reg  <= 2'd0;
      held_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      key_reg   <= Key_In;
      presc_reg <= presc_next;
      ms_reg    <= ms_next;
      valid_reg <= valid_next;
      code_reg  <= code_next;
      type_reg  <= type_next;
      held_reg  <= held_next;
    end
  end

  assign Event_Valid = valid_reg;
  assign Event_Code  = code_reg;
  assign Event_Type  = type_reg;
  assign Key_Held    = held_reg;

endmodule

// File: tb/tb_key_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_key_event_decoder
//
// Self-checking bench for key_event_decoder with CLK_FREQ_HZ=10000, HOLD_MS=5,
// REPEAT_MS=2 (10 cycles per ms). Directed scenario tasks check timing against
// hand-derived cycle numbers; a randomized task compares every cycle against a
// behavioural model that works in "cycles since last event" instead of
// prescaler/ms counters. Honors KEY_RELEASE_EVENT_EN when defined.
// -----------------------------------------------------------------------------
module tb_key_event_decoder;

  localparam int CLK_HZ = 10000;
  localparam int HOLD   = 5;
  localparam int REP    = 2;
  localparam int TPM    = CLK_HZ / 1000;
`ifdef KEY_RELEASE_EVENT_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic       CLK    = 1'b0;
  logic       RST_N  = 1'b0;
  logic [3:0] Key_In = 4'hF;
  logic       Event_Valid;
  logic [1:0] Event_Code;
  logic [1:0] Event_Type;
  logic       Key_Held;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  key_event_decoder #(
    .CLK_FREQ_HZ (CLK_HZ),
    .HOLD_MS     (HOLD),
    .REPEAT_MS   (REP)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .Key_In      (Key_In),
    .Event_Valid (Event_Valid),
    .Event_Code  (Event_Code),
    .Event_Type  (Event_Type),
    .Key_Held    (Key_Held)
  );

  // ---------------------------------------------------------------------------
  // Reference model: trk = tracked key index or -1, age = cycles since the last
  // event; a repeat is due when age reaches HOLD or REPEAT milliseconds.
  // ---------------------------------------------------------------------------
  typedef struct {
    int         trk;
    int         age;
    bit         rep;
    logic       valid;
    logic [1:0] code;
    logic [1:0] typ;
    logic [3:0] kr;
  } mdl_t;

  mdl_t mdl;

  function automatic mdl_t model_step(input mdl_t m, input logic [3:0] key_in);
    mdl_t n;
    int   hi;
    n       = m;
    n.valid = 1'b0;
    n.kr    = key_in;
    if (m.trk < 0) begin
      if (m.kr != 4'hF && !m.valid) begin
        hi = 3;
        while (m.kr[hi]) hi--;
        n.trk   = hi;
        n.code  = 2'(hi);
        n.typ   = 2'b00;
        n.valid = 1'b1;
        n.age   = 0;
        n.rep   = 1'b0;
      end
    end else if (m.kr[m.trk]) begin
      if (!REL_EN) begin
        n.trk = -1;
      end else if (!m.valid) begin
        n.trk   = -1;
        n.valid = 1'b1;
        n.typ   = 2'b10;
      end
    end else begin
      n.age = m.age + 1;
      if (n.age >= (m.rep ? REP * TPM : HOLD * TPM) && !m.valid) begin
        n.valid = 1'b1;
        n.typ   = 2'b01;
        n.age   = 0;
        n.rep   = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mdl.trk   <= -1;
      mdl.age   <= 0;
      mdl.rep   <= 1'b0;
      mdl.valid <= 1'b0;
      mdl.code  <= 2'd0;
      mdl.typ   <= 2'd0;
      mdl.kr    <= 4'hF;
    end else begin
      mdl <= model_step(mdl, Key_In);
    end
  end

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    RST_N  = 1'b0;
    Key_In = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      tests_run++;
      if ({Event_Valid, Event_Code, Event_Type, Key_Held} !== 6'b0) begin
        tests_failed++;
        $display("FAIL reset_outputs: got valid=%b code=%0d type=%0d held=%b, want all 0",
                 Event_Valid, Event_Code, Event_Type, Key_Held);
      end
    end
    RST_N = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      tests_run++;
      if (Event_Valid !== 1'b0 || Key_Held !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle_quiet cycle %0d: got valid=%b held=%b, want 0 0", k, Event_Valid, Key_Held);
      end
    end
    $display("[TB] test_reset: reset and 20 idle cycles checked");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single_press();
    int         ek[$];
    logic [1:0] ec[$];
    logic [1:0] et[$];
    int         n_after;
    logic       held1, held2;
    Key_In = 4'b1011;
    for (int k = 1; k <= 30; k++) begin
      @(negedge CLK);
      if (Event_Valid === 1'b1) begin
        ek.push_back(k); ec.push_back(Event_Code); et.push_back(Event_Type);
      end
    end
    tests_run++;
    if (ek.size() != 1 || ek[0] != 2 || ec[0] !== 2'd2 || et[0] !== 2'b00) begin
      tests_failed++;
      $display("FAIL single_press: got %0d events (first k=%0d code=%0d type=%0d), want 1 at k=2 code=2 type=0",
               ek.size(), (ek.size() > 0) ? ek[0] : -1, (ec.size() > 0) ? ec[0] : 2'd0,
               (et.size() > 0) ? et[0] : 2'd0);
    end
    Key_In  = 4'hF;
    n_after = 0;
    held1   = 1'b0;
    held2   = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      if (k == 1) held1 = Key_Held;
      if (k == 2) held2 = Key_Held;
      if (Event_Valid === 1'b1) n_after++;
    end
    tests_run++;
    if (held1 !== 1'b1 || held2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_held_drop: got held k1=%b k2=%b, want 1 0", held1, held2);
    end
    tests_run++;
    if (n_after != (REL_EN ? 1 : 0)) begin
      tests_failed++;
      $display("FAIL single_after_release: got %0d events, want %0d", n_after, REL_EN ? 1 : 0);
    end
    $display("[TB] test_single_press: press at k=2 and release checked");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_repeat();
    int         ek[$];
    logic [1:0] ec[$];
    logic [1:0] et[$];
    int         exp_k[5];
    int         n_after;
    exp_k = '{2, 2 + HOLD * TPM, 2 + (HOLD + REP) * TPM,
              2 + (HOLD + 2 * REP) * TPM, 2 + (HOLD + 3 * REP) * TPM};
    Key_In = 4'b0111;
    for (int k = 1; k <= 120; k++) begin
      @(negedge CLK);
      if (Event_Valid === 1'b1) begin
        ek.push_back(k); ec.push_back(Event_Code); et.push_back(Event_Type);
      end
    end
    tests_run++;
    if (ek.size() != 5) begin
      tests_failed++;
      $display("FAIL repeat_count: got %0d events while held, want 5", ek.size());
    end
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (i >= ek.size() || ek[i] != exp_k[i] || ec[i] !== 2'd3 || et[i] !== ((i == 0) ? 2'b00 : 2'b01)) begin
        tests_failed++;
        $display("FAIL repeat_event%0d: got k=%0d code=%0d type=%0d, want k=%0d code=3 type=%0d",
                 i, (i < ek.size()) ? ek[i] : -1, (i < ec.size()) ? ec[i] : 2'd0,
                 (i < et.size()) ? et[i] : 2'd0, exp_k[i], (i == 0) ? 0 : 1);
      end
    end
    Key_In  = 4'hF;
    n_after = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (Event_Valid === 1'b1) n_after++;
    end
    tests_run++;
    if (n_after != (REL_EN ? 1 : 0)) begin
      tests_failed++;
      $display("FAIL repeat_after_release: got %0d events, want %0d", n_after, REL_EN ? 1 : 0);
    end
    $display("[TB] test_repeat: press + %0d repeats observed", (ek.size() > 0) ? ek.size() - 1 : 0);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_priority();
    int         ek[$];
    logic [1:0] ec[$];
    logic [1:0] et[$];
    int         n_press, press_k, n_rel;
    logic [1:0] press_c;
    logic       held1, held2;
    Key_In = 4'b0110;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      if (Event_Valid === 1'b1) begin
        ek.push_back(k); ec.push_back(Event_Code); et.push_back(Event_Type);
      end
    end
    tests_run++;
    if (ek.size() != 1 || ek[0] != 2 || ec[0] !== 2'd3 || et[0] !== 2'b00) begin
      tests_failed++;
      $display("FAIL priority_up: got %0d events (first code=%0d), want 1 press code=3 at k=2",
               ek.size(), (ec.size() > 0) ? ec[0] : 2'd0);
    end
    Key_In  = 4'b1110;
    n_press = 0;
    n_rel   = 0;
    press_k = -1;
    press_c = 2'd3;
    held1   = 1'b0;
    held2   = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      if (k == 1) held1 = Key_Held;
      if (k == 2) held2 = Key_Held;
      if (Event_Valid === 1'b1 && Event_Type === 2'b00) begin
        n_press++; press_k = k; press_c = Event_Code;
      end
      if (Event_Valid === 1'b1 && Event_Type === 2'b10) n_rel++;
    end
    tests_run++;
    if (held1 !== 1'b1 || held2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL priority_idle_gap: got held k1=%b k2=%b, want 1 0", held1, held2);
    end
    tests_run++;
    if (n_press != 1 || press_k != (REL_EN ? 4 : 3) || press_c !== 2'd0) begin
      tests_failed++;
      $display("FAIL priority_right: got %0d presses k=%0d code=%0d, want 1 at k=%0d code=0",
               n_press, press_k, press_c, REL_EN ? 4 : 3);
    end
    tests_run++;
    if (n_rel != (REL_EN ? 1 : 0)) begin
      tests_failed++;
      $display("FAIL priority_release: got %0d release events, want %0d", n_rel, REL_EN ? 1 : 0);
    end
    Key_In = 4'hF;
    repeat (8) @(negedge CLK);
    $display("[TB] test_priority: Up tracked, Right pressed after release");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_repeat();
    int         ek[$];
    logic [1:0] ec[$];
    logic [1:0] et[$];
    Key_In = 4'b0111;
    repeat (60) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    tests_run++;
    if ({Event_Valid, Event_Code, Event_Type, Key_Held} !== 6'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got valid=%b code=%0d type=%0d held=%b right after RST_N fall, want all 0",
               Event_Valid, Event_Code, Event_Type, Key_Held);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      tests_run++;
      if ({Event_Valid, Event_Code, Event_Type, Key_Held} !== 6'b0) begin
        tests_failed++;
        $display("FAIL midrep_reset cycle %0d: got valid=%b code=%0d type=%0d held=%b, want all 0",
                 k, Event_Valid, Event_Code, Event_Type, Key_Held);
      end
    end
    RST_N = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge CLK);
      if (Event_Valid === 1'b1) begin
        ek.push_back(k); ec.push_back(Event_Code); et.push_back(Event_Type);
      end
    end
    tests_run++;
    if (ek.size() != 2 || ek[0] != 2 || et[0] !== 2'b00 || ec[0] !== 2'd3 ||
        ek[1] != 2 + HOLD * TPM || et[1] !== 2'b01 || ec[1] !== 2'd3) begin
      tests_failed++;
      $display("FAIL midrep_restart: got %0d events (k0=%0d k1=%0d), want press k=2 then repeat k=%0d, code=3",
               ek.size(), (ek.size() > 0) ? ek[0] : -1, (ek.size() > 1) ? ek[1] : -1, 2 + HOLD * TPM);
    end
    Key_In = 4'hF;
    repeat (8) @(negedge CLK);
    $display("[TB] test_reset_mid_repeat: reset and restart checked");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_release_event();
    int         pk, rk, np, nr;
    logic [1:0] pc, rc;
    pk = -1; rk = -1; np = 0; nr = 0; pc = 2'd0; rc = 2'd0;
    Key_In = 4'b1101;
    for (int k = 1; k <= 15; k++) begin
      @(negedge CLK);
      if (Event_Valid === 1'b1) begin
        np++; pk = k; pc = Event_Code;
        tests_run++;
        if (Event_Type !== 2'b00) begin
          tests_failed++;
          $display("FAIL left_press_type: got type=%0d, want 0", Event_Type);
        end
      end
    end
    Key_In = 4'hF;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      if (Event_Valid === 1'b1) begin
        nr++; rk = k; rc = Event_Code;
        tests_run++;
        if (Event_Type !== 2'b10) begin
          tests_failed++;
          $display("FAIL left_release_type: got type=%0d, want 2", Event_Type);
        end
      end
    end
    tests_run++;
    if (np != 1 || pk != 2 || pc !== 2'd1) begin
      tests_failed++;
      $display("FAIL left_press: got %0d events k=%0d code=%0d, want 1 at k=2 code=1", np, pk, pc);
    end
    tests_run++;
    if (nr != (REL_EN ? 1 : 0) || (nr == 1 && (rk != 2 || rc !== 2'd1))) begin
      tests_failed++;
      $display("FAIL left_release: got %0d events k=%0d code=%0d, want %0d (k=2 code=1)",
               nr, rk, rc, REL_EN ? 1 : 0);
    end
    $display("[TB] test_release_event: press/release of Left checked");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random();
    logic       prev_valid;
    int         dur;
    logic [3:0] pat;
    prev_valid = 1'b0;
    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(0, 19) == 0) begin
        RST_N = 1'b0;
        repeat (3) begin
          @(negedge CLK);
          tests_run++;
          if ({Event_Valid, Key_Held} !== 2'b00) begin
            tests_failed++;
            $display("FAIL rand_reset: got valid=%b held=%b, want 0 0", Event_Valid, Key_Held);
          end
        end
        RST_N      = 1'b1;
        prev_valid = 1'b0;
      end
      dur = $urandom_range(1, 130);
      if ($urandom_range(0, 2) == 0) pat = 4'hF;
      else pat = 4'($urandom);
      Key_In = pat;
      for (int c = 0; c < dur; c++) begin
        @(negedge CLK);
        tests_run++;
        if ({Event_Valid, Event_Code, Event_Type, Key_Held} !==
            {mdl.valid, mdl.code, mdl.typ, (mdl.trk >= 0)}) begin
          tests_failed++;
          $display("FAIL rand_model seg %0d cyc %0d key=%b: got v=%b c=%0d t=%0d h=%b, want v=%b c=%0d t=%0d h=%b",
                   s, c, pat, Event_Valid, Event_Code, Event_Type, Key_Held,
                   mdl.valid, mdl.code, mdl.typ, (mdl.trk >= 0));
        end
        tests_run++;
        if (prev_valid === 1'b1 && Event_Valid === 1'b1) begin
          tests_failed++;
          $display("FAIL rand_back_to_back seg %0d cyc %0d: got valid high twice, want single-cycle strobe", s, c);
        end
        prev_valid = Event_Valid;
      end
    end
    $display("[TB] test_random: 60 random segments compared against model");
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_repeat();
    test_priority();
    test_reset_mid_repeat();
    test_release_event();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
